// File: rtl/spi_master_xfer_if.sv
// Bundle of the MCU-side handshake and SPI pin signals for spi_master_xfer.
// The master modport is the transfer engine; the slave modport is its environment.
interface spi_master_xfer_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        input  start, tx_data, miso,
        output sclk, mosi, cs_n, busy, done, rx_data
    );

    modport slave (
        output start, tx_data, miso,
        input  sclk, mosi, cs_n, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master: one DATA_W-bit word out on mosi and in from miso per accepted start.
// Define SPI_LSB_FIRST_EN for LSB-first wire order; the default build is MSB first.
module spi_master_xfer #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 3
) (
    input logic               clk,
    input logic               rst,
    spi_master_xfer_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic              phase_end;
    logic              last_bit;

    assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));

    // The wire-side bit of tx_sr is OUT_IDX; miso enters at the opposite end.
`ifdef SPI_LSB_FIRST_EN
    localparam int OUT_IDX = 0;
    assign tx_next = {1'b0, tx_sr[DATA_W-1:1]};
    assign rx_next = {bus.miso, rx_sr[DATA_W-1:1]};
`else
    localparam int OUT_IDX = DATA_W - 1;
    assign tx_next = {tx_sr[DATA_W-2:0], 1'b0};
    assign rx_next = {rx_sr[DATA_W-2:0], bus.miso};
`endif

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = LEAD;
            LEAD:    if (phase_end) state_d = HIGH;
            HIGH:    if (phase_end) state_d = LOW;
            LOW:     if (phase_end) state_d = last_bit ? DONE : HIGH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin and status outputs are registered from the next state, so they switch with it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bus.sclk    <= 1'b0;
            bus.mosi    <= 1'b0;
            bus.cs_n    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rx_data <= '0;
        end else begin
            state    <= state_d;
            div_cnt  <= (state_d != state || state == IDLE) ? '0 : div_cnt + 1'b1;
            bus.sclk <= (state_d == HIGH);
            bus.cs_n <= (state_d == IDLE) || (state_d == DONE);
            bus.busy <= (state_d != IDLE);
            bus.done <= (state_d == DONE);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr    <= bus.tx_data;
                        bit_cnt  <= '0;
                        bus.mosi <= bus.tx_data[OUT_IDX];
                    end
                end
                HIGH: begin
                    // Capture one cycle after sclk rises, leaving the slave a full clk of output delay.
                    if (div_cnt == '0) rx_sr <= rx_next;
                    if (phase_end) begin
                        tx_sr    <= tx_next;
                        bus.mosi <= tx_next[OUT_IDX];
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        if (last_bit) bus.rx_data <= rx_sr;
                        else          bit_cnt     <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
